// File: rtl/seq_suffix_detector.sv
// Serial pattern-detector DFA: accept is high while the last PAT_W valid bits equal the pattern.
// Latency: accept/match_cnt update one cycle after the completing bit is sampled (Moore output).
// No backpressure: a bit is consumed on every cycle with in_valid=1. Optional: SEQ_DET_PAT_LOAD_EN.
module seq_suffix_detector #(
  parameter int               PAT_W       = 3,
  parameter logic [PAT_W-1:0] PATTERN     = 3'b100,
  parameter int               MATCH_CNT_W = 8
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   in,
  input  logic                   in_valid,
  input  logic                   overlap,
  output logic                   accept,
  output logic [MATCH_CNT_W-1:0] match_cnt
`ifdef SEQ_DET_PAT_LOAD_EN
  ,
  input  logic                   pat_load,
  input  logic [PAT_W-1:0]       pat_in
`endif
);

  localparam int                     SW      = $clog2(PAT_W + 1);
  localparam logic [SW-1:0]          FULL    = SW'(PAT_W);
  localparam logic [MATCH_CNT_W-1:0] CNT_MAX = '1;

  logic [SW-1:0]          r_state;
  logic [SW-1:0]          w_state_nxt;
  logic [MATCH_CNT_W-1:0] r_match_cnt;
  logic [PAT_W-1:0]       w_pat;
  logic [PAT_W-1:0]       w_win;     // newest PAT_W bits, LSB = bit arriving now
  logic                   w_step;    // a data bit is consumed this cycle
  logic                   w_clear;   // pattern reload forces state back to 0
  logic                   w_hit;     // this cycle enters the full-match state
  int                     w_lim;     // longest prefix length allowed this step

`ifdef SEQ_DET_PAT_LOAD_EN
  logic [PAT_W-1:0] r_pat;

  // Runtime pattern register; reload wins over the data bit in the same cycle.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_pat <= PATTERN;
    end else if (pat_load) begin
      r_pat <= pat_in;
    end
  end

  assign w_pat   = r_pat;
  assign w_step  = in_valid & ~pat_load;
  assign w_clear = pat_load;
`else
  assign w_pat   = PATTERN;
  assign w_step  = in_valid;
  assign w_clear = 1'b0;
`endif

  // Bit history: only the last PAT_W-1 bits are ever needed, the current bit completes the window.
  // History is never cleared on restart; w_lim keeps stale bits out of the comparison.
  generate
    if (PAT_W == 1) begin : g_nohist
      assign w_win = in;
    end else begin : g_hist
      logic [PAT_W-2:0] r_hist;

      // Shift in each consumed bit.
      always_ff @(posedge clk) begin
        if (rst) begin
          r_hist <= '0;
        end else if (w_step) begin
          r_hist <= w_win[PAT_W-2:0];
        end
      end

      assign w_win = {r_hist, in};
    end
  endgenerate

  // Next state: longest pattern prefix ending at the new bit, bounded by how much history counts.
  always_comb begin
    w_state_nxt = r_state;
    w_hit       = 1'b0;
    w_lim       = 0;
    if (w_clear) begin
      w_state_nxt = '0;
    end else if (w_step) begin
      if (r_state == FULL) begin
        // Overlap keeps the matched bits as history; non-overlap restarts with only the new bit.
        w_lim = overlap ? PAT_W : 1;
      end else begin
        w_lim = int'(r_state) + 1;
      end
      w_state_nxt = '0;
      for (int k = 1; k <= PAT_W; k++) begin
        if ((k <= w_lim) &&
            (((w_win ^ (w_pat >> (PAT_W - k))) & ({PAT_W{1'b1}} >> (PAT_W - k))) == '0)) begin
          w_state_nxt = SW'(k);
        end
      end
      w_hit = (w_state_nxt == FULL);
    end
  end

  // State register.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= '0;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Saturating count of entries into the full-match state, including re-entry.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_match_cnt <= '0;
    end else if (w_hit && (r_match_cnt != CNT_MAX)) begin
      r_match_cnt <= r_match_cnt + 1'b1;
    end
  end

  assign accept    = (r_state == FULL);
  assign match_cnt = r_match_cnt;

endmodule

// File: tb/tb_seq_suffix_detector.sv
// Bench for seq_suffix_detector: four instances with different patterns share one stimulus stream.
// Each is compared every cycle against a queue-based suffix model; directed streams pin the model.
module tb_seq_suffix_detector;

  localparam int          ND      = 4;
  localparam int          PW [ND] = '{3, 3, 2, 1};
  localparam int          CW [ND] = '{8, 8, 2, 3};
  localparam logic [15:0] PP [ND] = '{16'h4, 16'h5, 16'h3, 16'h0};

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic          rst, in_b, in_valid, overlap;
  logic [ND-1:0] acc;
  logic [7:0]    cnt0, cnt1;
  logic [1:0]    cnt2;
  logic [2:0]    cnt3;
`ifdef SEQ_DET_PAT_LOAD_EN
  logic          pat_load;
  logic [2:0]    pat_in;
`endif

  seq_suffix_detector #(.PAT_W(3), .PATTERN(3'b100), .MATCH_CNT_W(8)) u0 (
    .clk(clk), .rst(rst), .in(in_b), .in_valid(in_valid), .overlap(overlap),
    .accept(acc[0]), .match_cnt(cnt0)
`ifdef SEQ_DET_PAT_LOAD_EN
    , .pat_load(pat_load), .pat_in(pat_in)
`endif
  );

  seq_suffix_detector #(.PAT_W(3), .PATTERN(3'b101), .MATCH_CNT_W(8)) u1 (
    .clk(clk), .rst(rst), .in(in_b), .in_valid(in_valid), .overlap(overlap),
    .accept(acc[1]), .match_cnt(cnt1)
`ifdef SEQ_DET_PAT_LOAD_EN
    , .pat_load(1'b0), .pat_in(3'b000)
`endif
  );

  seq_suffix_detector #(.PAT_W(2), .PATTERN(2'b11), .MATCH_CNT_W(2)) u2 (
    .clk(clk), .rst(rst), .in(in_b), .in_valid(in_valid), .overlap(overlap),
    .accept(acc[2]), .match_cnt(cnt2)
`ifdef SEQ_DET_PAT_LOAD_EN
    , .pat_load(1'b0), .pat_in(2'b00)
`endif
  );

  seq_suffix_detector #(.PAT_W(1), .PATTERN(1'b0), .MATCH_CNT_W(3)) u3 (
    .clk(clk), .rst(rst), .in(in_b), .in_valid(in_valid), .overlap(overlap),
    .accept(acc[3]), .match_cnt(cnt3)
`ifdef SEQ_DET_PAT_LOAD_EN
    , .pat_load(1'b0), .pat_in(1'b0)
`endif
  );

  int          n_checks = 0;
  int          n_errors = 0;
  bit          chk_en   = 1'b0;
  bit          hq [ND][$];
  int          m_s   [ND];
  int          m_cnt [ND];
  logic [15:0] m_pat [ND];

  function automatic int dut_cnt(input int i);
    case (i)
      0:       return int'(cnt0);
      1:       return int'(cnt1);
      2:       return int'(cnt2);
      default: return int'(cnt3);
    endcase
  endfunction

  // Longest k such that the last k history bits equal the first k pattern bits.
  function automatic int suffix_len(input bit h[$], input int w, input logic [15:0] p);
    int n;
    int top;
    bit ok;
    n   = h.size();
    top = (n < w) ? n : w;
    for (int k = top; k >= 1; k--) begin
      ok = 1'b1;
      for (int j = 0; j < k; j++) begin
        if (h[n-k+j] != p[w-1-j]) ok = 1'b0;
      end
      if (ok) return k;
    end
    return 0;
  endfunction

  task automatic check(input string nm, input int idx, input int act, input int exp);
    n_checks++;
    if (act != exp) begin
      n_errors++;
      $display("FAIL %s dut%0d t=%0t got %0d expected %0d", nm, idx, $time, act, exp);
    end
  endtask

  // Reference model: history of bits since the last restart, evaluated per the acceptance rule.
  always @(posedge clk) begin
    for (int i = 0; i < ND; i++) begin
      if (rst) begin
        hq[i].delete();
        m_s[i]   = 0;
        m_cnt[i] = 0;
        m_pat[i] = PP[i];
      end
`ifdef SEQ_DET_PAT_LOAD_EN
      else if (i == 0 && pat_load) begin
        m_pat[0] = {13'b0, pat_in};
        hq[0].delete();
        m_s[0] = 0;
      end
`endif
      else if (in_valid) begin
        if (m_s[i] == PW[i] && !overlap) hq[i].delete();
        hq[i].push_back(in_b);
        if (hq[i].size() > 16) void'(hq[i].pop_front());
        m_s[i] = suffix_len(hq[i], PW[i], m_pat[i]);
        if (m_s[i] == PW[i] && m_cnt[i] < (1 << CW[i]) - 1) m_cnt[i]++;
      end
    end
  end

  // Every-cycle comparison of all instances against the model.
  always @(posedge clk) begin
    #1;
    if (chk_en) begin
      for (int i = 0; i < ND; i++) begin
        check("model_accept", i, int'(acc[i]), (m_s[i] == PW[i]) ? 1 : 0);
        check("model_cnt", i, dut_cnt(i), m_cnt[i]);
      end
    end
  end

  task automatic step(input bit r, input bit v, input bit b);
    @(negedge clk);
    rst      = r;
    in_valid = v;
    in_b     = b;
`ifdef SEQ_DET_PAT_LOAD_EN
    pat_load = 1'b0;
`endif
    @(posedge clk);
    #1;
  endtask

  // Feed n valid bits (bits[n-1] first) and check accept of one instance after each.
  task automatic run_bits(input string nm, input int idx, input int n,
                          input logic [7:0] bits, input logic [7:0] exp_acc);
    for (int k = 0; k < n; k++) begin
      step(1'b0, 1'b1, bits[n-1-k]);
      check(nm, idx, int'(acc[idx]), int'(exp_acc[n-1-k]));
    end
  endtask

  initial begin
    logic [5:0] exp_c;
    rst      = 1'b1;
    in_valid = 1'b0;
    in_b     = 1'b0;
    overlap  = 1'b1;
`ifdef SEQ_DET_PAT_LOAD_EN
    pat_load = 1'b0;
    pat_in   = 3'b000;
`endif
    step(1'b1, 1'b0, 1'b0);
    chk_en = 1'b1;
    for (int i = 0; i < ND; i++) begin
      check("reset_accept", i, int'(acc[i]), 0);
      check("reset_cnt", i, dut_cnt(i), 0);
    end

    // 100 on 1,1,0,0; ends-with-0 on the same stream.
    run_bits("p100_acc", 0, 4, 8'b1100, 8'b0001);
    check("p100_cnt", 0, dut_cnt(0), 1);
    check("p0_acc", 3, int'(acc[3]), 1);
    check("p0_cnt", 3, dut_cnt(3), 2);

    // 101 overlapping vs non-overlapping.
    step(1'b1, 1'b0, 1'b0);
    run_bits("p101_ov_acc", 1, 5, 8'b10101, 8'b00101);
    check("p101_ov_cnt", 1, dut_cnt(1), 2);
    overlap = 1'b0;
    step(1'b1, 1'b0, 1'b0);
    run_bits("p101_nov_acc", 1, 5, 8'b10101, 8'b00100);
    check("p101_nov_cnt", 1, dut_cnt(1), 1);
    overlap = 1'b1;

    // Gap cycles with in=0 must not advance the state.
    step(1'b1, 1'b0, 1'b0);
    step(1'b0, 1'b1, 1'b1);
    for (int k = 0; k < 3; k++) begin
      step(1'b0, 1'b0, 1'b0);
      check("gap_acc", 0, int'(acc[0]), 0);
    end
    run_bits("gap_tail_acc", 0, 2, 8'b00, 8'b01);
    check("gap_cnt", 0, dut_cnt(0), 1);

    // 11 with a 2-bit saturating counter.
    step(1'b1, 1'b0, 1'b0);
    exp_c = 6'b000000;
    for (int k = 0; k < 6; k++) begin
      step(1'b0, 1'b1, 1'b1);
      check("p11_acc", 2, int'(acc[2]), (k == 0) ? 0 : 1);
      check("p11_cnt", 2, dut_cnt(2), (k > 3) ? 3 : k);
    end

    // Mid-stream reset discards the partial prefix.
    step(1'b1, 1'b0, 1'b0);
    step(1'b0, 1'b1, 1'b1);
    step(1'b0, 1'b1, 1'b0);
    step(1'b1, 1'b0, 1'b0);
    step(1'b0, 1'b1, 1'b0);
    check("rst_mid_acc", 0, int'(acc[0]), 0);
    check("rst_mid_cnt", 0, dut_cnt(0), 0);
    run_bits("rst_after_acc", 0, 3, 8'b100, 8'b001);

`ifdef SEQ_DET_PAT_LOAD_EN
    // Reload 011; counter continues from its earlier value.
    step(1'b1, 1'b0, 1'b0);
    run_bits("load_pre_acc", 0, 3, 8'b100, 8'b001);
    @(negedge clk);
    pat_load = 1'b1;
    pat_in   = 3'b011;
    in_valid = 1'b1;
    in_b     = 1'b0;
    @(posedge clk);
    #1;
    check("load_acc", 0, int'(acc[0]), 0);
    run_bits("load_post_acc", 0, 3, 8'b011, 8'b001);
    check("load_cnt", 0, dut_cnt(0), 2);
`endif

    // Randomised traffic; the compare process does the checking.
    step(1'b1, 1'b0, 1'b0);
    for (int c = 0; c < 3000; c++) begin
      if ($urandom_range(0, 15) == 0) overlap = 1'($urandom);
`ifdef SEQ_DET_PAT_LOAD_EN
      if ($urandom_range(0, 99) == 0) begin
        @(negedge clk);
        rst      = 1'b0;
        pat_load = 1'b1;
        pat_in   = 3'($urandom);
        in_valid = 1'($urandom);
        in_b     = 1'($urandom);
        @(posedge clk);
        #1;
        continue;
      end
`endif
      step(($urandom_range(0, 63) == 0), ($urandom_range(0, 3) != 0), 1'($urandom));
    end

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
